// File: rtl/match_controller.sv
// Best-of-N match sequencer wrapped around the game core: round lifecycle,
// round timer with health-decided timeouts, scoring, and overlay status.
module match_controller #(
    parameter int TICK_DIV       = 100_000_000,
    parameter int COUNTDOWN_SECS = 3,
    parameter int ROUND_SECS     = 99,
    parameter int HOLD_SECS      = 2,
    parameter int ROUNDS_TO_WIN  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic [1:0] finish,
    input  logic [3:0] p1_health,
    input  logic [3:0] p2_health,
    output logic       game_reset_n,
    output logic       fight_enable,
    output logic [2:0] state,
    output logic [2:0] countdown,
    output logic [6:0] round_time,
    output logic [2:0] round_num,
    output logic [1:0] p1_rounds,
    output logic [1:0] p2_rounds,
    output logic [1:0] round_winner,
    output logic [1:0] match_winner
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_COUNTDOWN  = 3'd1,
        S_FIGHT      = 3'd2,
        S_ROUND_OVER = 3'd3,
        S_MATCH_OVER = 3'd4
    } state_t;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    localparam logic [2:0] CD_INIT   = 3'(COUNTDOWN_SECS);
    localparam logic [6:0] RT_INIT   = 7'(ROUND_SECS);
    localparam logic [2:0] HOLD_INIT = 3'(HOLD_SECS);
    localparam logic [1:0] WIN_COUNT = 2'(ROUNDS_TO_WIN);

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_DRAW = 2'b10;
    localparam logic [1:0] RES_P2   = 2'b11;

    state_t        state_q;
    logic          start_s1, start_s2, start_s3;
    logic          start_pulse;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [2:0]    hold_cnt;

    assign state       = state_q;
    assign start_pulse = start_s2 & ~start_s3;
    assign tick        = (tick_cnt == TICK_LAST);

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    // Two flops resolve metastability on the raw button; the third remembers
    // the previous synchronised level so a held button yields a single pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_s1 <= 1'b0;
            start_s2 <= 1'b0;
            start_s3 <= 1'b0;
        end else begin
            start_s1 <= start_btn;
            start_s2 <= start_s1;
            start_s3 <= start_s2;
        end
    end

    // NOTE: all state lives in one clocked block with non-blocking assignments;
    // a later assignment in the same cycle overrides an earlier default, which
    // is how state transitions restart the tick counter below.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            game_reset_n <= 1'b0;
            fight_enable <= 1'b0;
            countdown    <= 3'd0;
            round_time   <= RT_INIT;
            round_num    <= 3'd0;
            p1_rounds    <= 2'd0;
            p2_rounds    <= 2'd0;
            round_winner <= RES_NONE;
            match_winner <= RES_NONE;
            tick_cnt     <= '0;
            hold_cnt     <= 3'd0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);

            case (state_q)
                S_IDLE, S_MATCH_OVER: begin
                    if (start_pulse) begin
                        state_q      <= S_COUNTDOWN;
                        tick_cnt     <= '0;
                        game_reset_n <= 1'b0;
                        fight_enable <= 1'b0;
                        p1_rounds    <= 2'd0;
                        p2_rounds    <= 2'd0;
                        round_winner <= RES_NONE;
                        match_winner <= RES_NONE;
                        round_num    <= 3'd1;
                        countdown    <= CD_INIT;
                    end
                end

                S_COUNTDOWN: begin
                    if (tick) begin
                        if (countdown == 3'd1) begin
                            state_q      <= S_FIGHT;
                            tick_cnt     <= '0;
                            countdown    <= 3'd0;
                            round_time   <= RT_INIT;
                            game_reset_n <= 1'b1;
                            fight_enable <= 1'b1;
                        end else begin
                            countdown <= countdown - 3'd1;
                        end
                    end
                end

                S_FIGHT: begin
                    // A KO takes priority over the timer expiring in the same cycle.
                    if (finish[0]) begin
                        state_q      <= S_ROUND_OVER;
                        tick_cnt     <= '0;
                        hold_cnt     <= HOLD_INIT;
                        fight_enable <= 1'b0;
                        round_winner <= finish;
                        if (finish[1]) p2_rounds <= sat_inc2(p2_rounds);
                        else           p1_rounds <= sat_inc2(p1_rounds);
                    end else if (tick) begin
                        if (round_time == 7'd1) begin
                            state_q      <= S_ROUND_OVER;
                            tick_cnt     <= '0;
                            hold_cnt     <= HOLD_INIT;
                            fight_enable <= 1'b0;
                            round_time   <= 7'd0;
                            if (p1_health > p2_health) begin
                                round_winner <= RES_P1;
                                p1_rounds    <= sat_inc2(p1_rounds);
                            end else if (p1_health < p2_health) begin
                                round_winner <= RES_P2;
                                p2_rounds    <= sat_inc2(p2_rounds);
                            end else begin
                                round_winner <= RES_DRAW;
                            end
                        end else begin
                            round_time <= round_time - 7'd1;
                        end
                    end
                end

                S_ROUND_OVER: begin
                    if (tick) begin
                        if (hold_cnt == 3'd1) begin
                            tick_cnt <= '0;
                            hold_cnt <= 3'd0;
                            if (p1_rounds == WIN_COUNT) begin
                                state_q      <= S_MATCH_OVER;
                                match_winner <= RES_P1;
                            end else if (p2_rounds == WIN_COUNT) begin
                                state_q      <= S_MATCH_OVER;
                                match_winner <= RES_P2;
                            end else begin
                                // Draws fall through here too: the round replays
                                // under the next round number.
                                state_q      <= S_COUNTDOWN;
                                game_reset_n <= 1'b0;
                                round_num    <= sat_inc3(round_num);
                                countdown    <= CD_INIT;
                            end
                        end else begin
                            hold_cnt <= hold_cnt - 3'd1;
                        end
                    end
                end

                default: begin
                    state_q      <= S_IDLE;
                    tick_cnt     <= '0;
                    game_reset_n <= 1'b0;
                    fight_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: directed round scenarios followed by random
// stimulus, all compared against an elapsed-time model of the match rules.
module tb_match_controller;

    localparam int TD  = 10;
    localparam int CS  = 3;
    localparam int RS  = 5;
    localparam int HS  = 2;
    localparam int RTW = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_btn;
    logic [1:0] finish;
    logic [3:0] p1_health, p2_health;
    logic       game_reset_n, fight_enable;
    logic [2:0] state, countdown, round_num;
    logic [6:0] round_time;
    logic [1:0] p1_rounds, p2_rounds, round_winner, match_winner;
    logic [31:0] dut_vec;

    always #5 clk = ~clk;

    match_controller #(
        .TICK_DIV(TD), .COUNTDOWN_SECS(CS), .ROUND_SECS(RS),
        .HOLD_SECS(HS), .ROUNDS_TO_WIN(RTW)
    ) dut (
        .clk(clk), .reset(reset), .start_btn(start_btn), .finish(finish),
        .p1_health(p1_health), .p2_health(p2_health),
        .game_reset_n(game_reset_n), .fight_enable(fight_enable),
        .state(state), .countdown(countdown), .round_time(round_time),
        .round_num(round_num), .p1_rounds(p1_rounds), .p2_rounds(p2_rounds),
        .round_winner(round_winner), .match_winner(match_winner)
    );

    assign dut_vec = {6'd0, state, game_reset_n, fight_enable, countdown, round_time,
                      round_num, p1_rounds, p2_rounds, round_winner, match_winner};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: state 0..4 as seen on the output, plus cycles spent in it.
    int m_state, m_cyc, m_rt, m_rn, m_p1, m_p2, m_rw, m_mw;
    bit b0, b1, b2;

    function automatic int sat_inc(input int v, input int lim);
        return (v >= lim) ? v : v + 1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_cyc = 0; m_rt = RS; m_rn = 0;
        m_p1 = 0; m_p2 = 0; m_rw = 0; m_mw = 0;
        b0 = 0; b1 = 0; b2 = 0;
    endtask

    task automatic model_step();
        bit pulse;
        int nxt;
        int done;
        if (reset) begin
            model_reset();
            return;
        end
        pulse = b1 & ~b2;
        b2 = b1; b1 = b0; b0 = start_btn;
        nxt  = m_state;
        done = m_cyc + 1;
        case (m_state)
            0, 4: if (pulse) begin
                m_p1 = 0; m_p2 = 0; m_rw = 0; m_mw = 0; m_rn = 1; nxt = 1;
            end
            1: if (done == CS * TD) begin
                m_rt = RS; nxt = 2;
            end
            2: if (finish[0]) begin
                m_rw = int'(finish);
                if (finish[1]) m_p2 = sat_inc(m_p2, 3);
                else           m_p1 = sat_inc(m_p1, 3);
                m_rt = RS - m_cyc / TD;
                nxt = 3;
            end else if (done == RS * TD) begin
                m_rt = 0;
                if (p1_health > p2_health)      begin m_rw = 1; m_p1 = sat_inc(m_p1, 3); end
                else if (p1_health < p2_health) begin m_rw = 3; m_p2 = sat_inc(m_p2, 3); end
                else                                  m_rw = 2;
                nxt = 3;
            end
            3: if (done == HS * TD) begin
                if (m_p1 == RTW)      begin m_mw = 1; nxt = 4; end
                else if (m_p2 == RTW) begin m_mw = 3; nxt = 4; end
                else begin m_rn = (m_rn >= 7) ? 7 : m_rn + 1; nxt = 1; end
            end
            default: nxt = 0;
        endcase
        if (nxt != m_state) begin
            m_state = nxt;
            m_cyc   = 0;
        end else begin
            m_cyc++;
        end
    endtask

    function automatic logic [31:0] expected();
        int cd;
        int rt;
        cd = (m_state == 1) ? CS - m_cyc / TD : 0;
        rt = (m_state == 2) ? RS - m_cyc / TD : m_rt;
        return {6'd0, 3'(m_state), (m_state >= 2), (m_state == 2), 3'(cd), 7'(rt),
                3'(m_rn), 2'(m_p1), 2'(m_p2), 2'(m_rw), 2'(m_mw)};
    endfunction

    // One clock: model advances on the edge, DUT is compared on the falling edge.
    task automatic cycle(input string tag = "cycle");
        @(posedge clk);
        model_step();
        @(negedge clk);
        check(tag, dut_vec, expected());
    endtask

    initial begin
        reset = 1'b1; start_btn = 1'b0; finish = 2'b00;
        p1_health = 4'd0; p2_health = 4'd0;
        model_reset();
        #1;
        check("async_reset_state", 32'(state), 0);
        check("async_reset_grn", 32'(game_reset_n), 0);
        check("async_reset_rt", 32'(round_time), RS);
        repeat (3) cycle("reset_hold");
        reset = 1'b0;
        repeat (2) cycle("idle");

        // Held start button: one pulse, COUNTDOWN on the third edge.
        start_btn = 1'b1;
        repeat (2) cycle();
        check("start_lat2", 32'(state), 0);
        cycle();
        check("start_state", 32'(state), 1);
        check("start_round", 32'(round_num), 1);
        check("start_cd", 32'(countdown), 3);
        repeat (10) cycle();
        check("cd_two", 32'(countdown), 2);
        repeat (7) cycle();
        start_btn = 1'b0;
        repeat (3) cycle();
        check("cd_one", 32'(countdown), 1);
        repeat (9) cycle();
        check("cd_last", 32'(state), 1);
        cycle();
        check("fight_state", 32'(state), 2);
        check("fight_grn", 32'(game_reset_n), 1);
        check("fight_en", 32'(fight_enable), 1);

        // KO by P1.
        finish = 2'b01;
        cycle();
        finish = 2'b00;
        check("ko_state", 32'(state), 3);
        check("ko_winner", 32'(round_winner), 1);
        check("ko_p1", 32'(p1_rounds), 1);
        check("ko_fe", 32'(fight_enable), 0);
        repeat (19) cycle();
        check("hold_state", 32'(state), 3);
        cycle();
        check("next_state", 32'(state), 1);
        check("next_round", 32'(round_num), 2);
        check("next_grn", 32'(game_reset_n), 0);
        repeat (30) cycle();

        // Timeout won on health by P2.
        p1_health = 4'd7; p2_health = 4'd9;
        repeat (49) cycle();
        check("to_rt1", 32'(round_time), 1);
        cycle();
        check("to_rt0", 32'(round_time), 0);
        check("to_winner", 32'(round_winner), 3);
        check("to_p2", 32'(p2_rounds), 1);
        repeat (50) cycle();

        // Timeout with equal health: draw, replayed as round 4.
        p1_health = 4'd5; p2_health = 4'd5;
        repeat (50) cycle();
        check("draw_winner", 32'(round_winner), 2);
        check("draw_scores", 32'({p1_rounds, p2_rounds}), 32'h5);
        repeat (20) cycle();
        check("draw_replay", 32'(round_num), 4);
        repeat (30) cycle();

        // KO by P2 on the expiring tick while P1 leads on health.
        p1_health = 4'd9; p2_health = 4'd3;
        repeat (49) cycle();
        finish = 2'b11;
        cycle();
        finish = 2'b00;
        check("tie_winner", 32'(round_winner), 3);
        check("tie_scores", 32'({p1_rounds, p2_rounds}), 32'h6);
        check("tie_rt", 32'(round_time), 1);

        // Match end and hold.
        repeat (20) cycle();
        check("match_state", 32'(state), 4);
        check("match_winner", 32'(match_winner), 3);
        for (int i = 0; i < 100; i++) begin
            finish = 2'($urandom_range(0, 3));
            p1_health = 4'($urandom); p2_health = 4'($urandom);
            cycle("match_hold");
        end
        check("match_p2", 32'(p2_rounds), 2);
        start_btn = 1'b1;
        repeat (3) cycle();
        start_btn = 1'b0;
        finish = 2'b00;
        check("rematch_state", 32'(state), 1);
        check("rematch_scores", 32'({p1_rounds, p2_rounds}), 0);
        check("rematch_round", 32'(round_num), 1);
        check("rematch_winner", 32'(match_winner), 0);

        // Asynchronous reset in the middle of a fight.
        repeat (42) cycle();
        #2 reset = 1'b1;
        #1;
        check("mid_reset_vec", dut_vec,
              {6'd0, 3'd0, 1'b0, 1'b0, 3'd0, 7'(RS), 3'd0, 2'd0, 2'd0, 2'd0, 2'd0});
        repeat (2) cycle("mid_reset_hold");
        reset = 1'b0;

        // Random play.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) start_btn = ~start_btn;
            if ($urandom_range(0, 7) == 0) begin
                p1_health = 4'($urandom);
                p2_health = 4'($urandom);
            end
            if (m_state == 2) begin
                case ($urandom_range(0, 59))
                    0:       finish = 2'b01;
                    1:       finish = 2'b11;
                    2:       finish = 2'b10;
                    default: finish = 2'b00;
                endcase
            end else begin
                finish = 2'($urandom_range(0, 3));
            end
            reset = ($urandom_range(0, 999) == 0);
            cycle("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Sequences a best-of-N match around the `game` core. It owns the round lifecycle: idle, pre-round countdown, fight, round-over hold, match-over.
- Consumes `game`'s `finish` and health outputs and drives `game`'s active-low reset, plus an enable that gates the player input buses upstream of `game`.
- Adds a round time limit, with the round decided on health when the timer expires.
- Provides scores, round number and timers for the VGA overlay.

Parameters:
- TICK_DIV, 100_000_000: clk cycles per one-second tick.
- COUNTDOWN_SECS, 3: pre-round countdown length in ticks (1..7).
- ROUND_SECS, 99: round time limit in ticks (1..127).
- HOLD_SECS, 2: round-over display time in ticks (1..7).
- ROUNDS_TO_WIN, 2: round wins needed to take the match (1..3).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- start_btn  in  1  raw start button, asynchronous to clk, level
- finish  in  2  from game: 00 in play, 01 P1 KO win, 11 P2 KO win
- p1_health  in  4  from game
- p2_health  in  4  from game
- game_reset_n  out  1  to game reset input (game resets while low)
- fight_enable  out  1  high only while players may act; upstream ANDs it into p1_inputs/p2_inputs
- state  out  3  0 IDLE, 1 COUNTDOWN, 2 FIGHT, 3 ROUND_OVER, 4 MATCH_OVER
- countdown  out  3  seconds remaining in COUNTDOWN, else 0
- round_time  out  7  seconds remaining in the round
- round_num  out  3  current round, 1-based (0 in IDLE)
- p1_rounds  out  2  P1 round wins
- p2_rounds  out  2  P2 round wins
- round_winner  out  2  last round result: 00 none, 01 P1, 11 P2, 10 draw
- match_winner  out  2  00 none, 01 P1, 11 P2

Behaviour:
- Reset values:
  - state=IDLE; game_reset_n=0; fight_enable=0.
  - countdown=0; round_time=ROUND_SECS; round_num=0.
  - p1_rounds=p2_rounds=0; round_winner=00; match_winner=00.
  - Tick counter=0; start synchroniser flops=0.
- start_btn path:
  - Two-flop synchroniser, then rising-edge detect, giving start_pulse, a 1-cycle pulse.
  - Latency is 3 clk from the input edge.
  - A held button produces only one pulse.
- Tick generator:
  - Counter runs 0..TICK_DIV-1; `tick` pulses for 1 cycle when the count is TICK_DIV-1.
  - The counter clears on every state transition, so the first tick in a state arrives TICK_DIV cycles after entry.
- game_reset_n is registered:
  - 0 in IDLE and COUNTDOWN.
  - 1 in FIGHT, ROUND_OVER and MATCH_OVER, so game freezes on its own finish and positions stay visible.
- fight_enable is registered; it is 1 only in FIGHT.
- IDLE:
  - start_pulse leads to COUNTDOWN.
  - Clear the scores and round_winner, set round_num=1, load countdown=COUNTDOWN_SECS.
- COUNTDOWN:
  - On tick, countdown decrements.
  - On a tick with countdown==1: set countdown=0, load round_time=ROUND_SECS, go to FIGHT.
  - finish is ignored (game is held in reset).
- FIGHT:
  - Priority 1: if finish[0]==1, go to ROUND_OVER.
    - round_winner=finish.
    - Increment the winner's round counter.
    - round_time freezes.
  - Priority 2: else on tick, decrement round_time.
    - A tick with round_time==1 sets round_time=0 and goes to ROUND_OVER.
    - The result uses health sampled that cycle: p1_health>p2_health gives 01 (P1 +1); < gives 11 (P2 +1); equal gives 10 (no score).
  - If finish[0] rises on the same cycle as the expiring tick, finish wins (KO beats the timer).
- ROUND_OVER:
  - Hold for HOLD_SECS ticks, using an internal hold counter loaded on entry.
  - On the final tick, if p1_rounds or p2_rounds equals ROUNDS_TO_WIN, go to MATCH_OVER and set match_winner to 01 or 11.
  - Otherwise go to COUNTDOWN: round_num+1, countdown=COUNTDOWN_SECS.
  - A draw replays the round with round_num incremented.
  - round_num saturates at 7.
  - Round counters saturate at 3.
- MATCH_OVER:
  - All outputs hold.
  - start_pulse starts a new match: same actions as from IDLE, next state COUNTDOWN, match_winner=00.
- start_pulse is ignored in COUNTDOWN, FIGHT and ROUND_OVER.
- Reset asserted mid-operation returns to the reset values immediately (asynchronous). The first start_pulse after reset release is honoured only from IDLE.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
All scenarios use TICK_DIV=10, COUNTDOWN_SECS=3, ROUND_SECS=5, HOLD_SECS=2, ROUNDS_TO_WIN=2.

1. Start pulse:
   - Stimulus: reset, then pulse start_btn high for 20 clk.
   - Required: exactly one transition to COUNTDOWN, 3 clk after the edge, with round_num=1 and countdown=3.
   - Required: countdown reaches 2 then 1 at 10-clk intervals; FIGHT is entered 30 clk after entry with game_reset_n=1 and fight_enable=1.
2. KO round:
   - Stimulus: in FIGHT, drive finish=01.
   - Required: next clk state=ROUND_OVER, round_winner=01, p1_rounds=1, fight_enable=0.
   - Required: 20 clk later state=COUNTDOWN, round_num=2, game_reset_n=0.
3. Timeout:
   - Stimulus: finish=00 with p1_health=7, p2_health=9.
   - Required: after 50 clk in FIGHT, round_time=0, round_winner=11, p2_rounds=1.
   - Repeat with equal health: round_winner=10, no score change, round replays.
4. Tie-break:
   - Stimulus: finish=11 asserted on the same cycle as the expiring tick, with p1_health > p2_health.
   - Required: round_winner=11 and only p2_rounds increments.
5. Match end:
   - Stimulus: P2 wins two rounds.
   - Required: MATCH_OVER, match_winner=11, p2_rounds=2, outputs stable for 100 clk.
   - Required: a later start pulse gives COUNTDOWN with scores 0, round_num=1, match_winner=00.
6. Reset:
   - Stimulus: assert reset mid-FIGHT, between clk edges.
   - Required: outputs reach reset values before the next clk edge; game_reset_n=0.
